// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared constants for the FIFO control stage: state encodings, sizes, threshold defaults
package fifo_ctrl_pkg;

   localparam int STATE_W = 5;

   localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
   localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
   localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
   localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
   localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

   localparam int FIFO_DEPTH      = 8;
   localparam int FIFO_PTR_W      = 3;
   localparam int FIFO_AF_DEFAULT = 6;
   localparam int FIFO_AE_DEFAULT = 1;

endpackage

// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - request/status bundle of fifo_ctrl; FIFO_CTRL_PEAK_EN adds the peak signal
interface fifo_ctrl_if
   import fifo_ctrl_pkg::*;
#(
   parameter int PTR_W = FIFO_PTR_W
);
   logic               init;
   logic [PTR_W:0]     umbral_alto;
   logic [PTR_W:0]     umbral_bajo;
   logic               push;
   logic               pop;
   logic               mem_wr_en;
   logic               mem_rd_en;
   logic               valid_out;
   logic [PTR_W:0]     count;
   logic               full;
   logic               empty;
   logic               almost_full;
   logic               almost_empty;
   logic               error;
   logic [STATE_W-1:0] state;
`ifdef FIFO_CTRL_PEAK_EN
   logic [PTR_W:0]     peak;
`endif

   modport slave (
      input  init, umbral_alto, umbral_bajo, push, pop,
      output mem_wr_en, mem_rd_en, valid_out, count, full, empty,
             almost_full, almost_empty, error, state
`ifdef FIFO_CTRL_PEAK_EN
             , peak
`endif
   );

   modport master (
      output init, umbral_alto, umbral_bajo, push, pop,
      input  mem_wr_en, mem_rd_en, valid_out, count, full, empty,
             almost_full, almost_empty, error, state
`ifdef FIFO_CTRL_PEAK_EN
             , peak
`endif
   );

endinterface

// File: rtl/fifo_cnt.sv
// rtl/fifo_cnt.sv - FIFO occupancy counter driven by accepted write/read strobes
module fifo_cnt #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           wr_ok,
   input  logic           rd_ok,
   output logic [PTR_W:0] count,
   output logic [PTR_W:0] count_nxt,
   output logic           full,
   output logic           empty
);
   localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_C  = (PTR_W+1)'(1);

   always_comb begin
      count_nxt = count;
      if (wr_ok && !rd_ok)
         count_nxt = count + ONE_C;
      else if (rd_ok && !wr_ok)
         count_nxt = count - ONE_C;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else
         count <= count_nxt;
   end

   assign full  = (count == FULL_C);
   assign empty = (count == '0);

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - push/pop arbitration, flags and error FSM in front of the FIFO memory
// FIFO_CTRL_PEAK_EN adds a high-water-mark output (peak).
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int PTR_W      = FIFO_PTR_W,
   parameter int AF_DEFAULT = FIFO_AF_DEFAULT,
   parameter int AE_DEFAULT = FIFO_AE_DEFAULT
) (
   input logic        clk,
   input logic        reset,
   fifo_ctrl_if.slave bus
);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(AF_DEFAULT);
   localparam logic [PTR_W:0] AE_C    = (PTR_W+1)'(AE_DEFAULT);

   logic [STATE_W-1:0] state_q, state_d;
   logic [PTR_W:0]     alto_q, bajo_q;
   logic [PTR_W:0]     count, count_nxt;
   logic               full, empty;
   logic               error_q, valid_q;
   logic               accept, wr_ok, rd_ok, err_ev;

   // A simultaneous pop frees a slot, so a push into a full FIFO is still legal.
   assign accept = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
   assign wr_ok  = accept && bus.push && ((count < DEPTH_C) || bus.pop);
   assign rd_ok  = accept && bus.pop && (count != '0);
   assign err_ev = accept && ((bus.push && !wr_ok) || (bus.pop && !rd_ok));

   fifo_cnt #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .wr_ok     (wr_ok),
      .rd_ok     (rd_ok),
      .count     (count),
      .count_nxt (count_nxt),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!bus.init) state_d = ST_IDLE;
         ST_IDLE: begin
            if (err_ev)        state_d = ST_ERROR;
            else if (bus.init) state_d = ST_INIT;
            else if (wr_ok)    state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (err_ev)                 state_d = ST_ERROR;
            else if (count_nxt == '0)   state_d = ST_IDLE;
         end
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RESET;
         alto_q  <= AF_C;
         bajo_q  <= AE_C;
         error_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= rd_ok;
         if (err_ev)
            error_q <= 1'b1;
         if ((state_q == ST_INIT) && bus.init) begin
            alto_q <= bus.umbral_alto;
            bajo_q <= bus.umbral_bajo;
         end
      end
   end

`ifdef FIFO_CTRL_PEAK_EN
   logic [PTR_W:0] peak_q;

   always_ff @(posedge clk) begin
      if (reset)
         peak_q <= '0;
      else if (count_nxt > peak_q)
         peak_q <= count_nxt;
   end

   assign bus.peak = peak_q;
`endif

   assign bus.mem_wr_en    = wr_ok;
   assign bus.mem_rd_en    = rd_ok;
   assign bus.valid_out    = valid_q;
   assign bus.count        = count;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= alto_q);
   assign bus.almost_empty = (count <= bajo_q);
   assign bus.error        = error_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed and randomized check of fifo_ctrl against an occupancy model
// FIFO_CTRL_PEAK_EN also checks the peak output.
module tb_fifo_ctrl;

   localparam int P_RESET  = 0;
   localparam int P_INIT   = 1;
   localparam int P_IDLE   = 2;
   localparam int P_ACTIVE = 3;
   localparam int P_ERROR  = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   int m_phase, m_cnt, m_alto, m_bajo, m_peak;
   bit m_err, m_vld, m_known = 1'b0;

   fifo_ctrl_if #(.PTR_W(3)) bus ();

   fifo_ctrl #(
      .DEPTH      (8),
      .PTR_W      (3),
      .AF_DEFAULT (6),
      .AE_DEFAULT (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at the falling edge, check enables, step the model, check state after the edge.
   task automatic cyc(input bit r, input bit in_init, input int alto, input int bajo,
                      input bit pu, input bit po);
      bit ok_ph, wr, rd;
      @(negedge clk);
      reset           = r;
      bus.init        = in_init;
      bus.umbral_alto = 4'(alto);
      bus.umbral_bajo = 4'(bajo);
      bus.push        = pu;
      bus.pop         = po;
      #1;
      ok_ph = m_known && (m_phase == P_IDLE || m_phase == P_ACTIVE);
      wr    = ok_ph && pu && (m_cnt < 8 || po);
      rd    = ok_ph && po && (m_cnt > 0);
      if (m_known) begin
         chk("mem_wr_en", int'(bus.mem_wr_en), int'(wr));
         chk("mem_rd_en", int'(bus.mem_rd_en), int'(rd));
      end
      if (r) begin
         m_known = 1'b1;
         m_phase = P_RESET;
         m_cnt   = 0;
         m_alto  = 6;
         m_bajo  = 1;
         m_err   = 1'b0;
         m_vld   = 1'b0;
         m_peak  = 0;
      end else if (m_known) begin
         m_vld = rd;
         case (m_phase)
            P_RESET: m_phase = P_INIT;
            P_INIT: begin
               if (in_init) begin
                  m_alto = alto & 15;
                  m_bajo = bajo & 15;
               end else begin
                  m_phase = P_IDLE;
               end
            end
            P_IDLE, P_ACTIVE: begin
               m_cnt = m_cnt + int'(wr) - int'(rd);
               if (m_cnt > m_peak) m_peak = m_cnt;
               if ((pu && !wr) || (po && !rd)) begin
                  m_err   = 1'b1;
                  m_phase = P_ERROR;
               end else if (m_phase == P_IDLE) begin
                  if (in_init)  m_phase = P_INIT;
                  else if (wr)  m_phase = P_ACTIVE;
               end else if (m_cnt == 0) begin
                  m_phase = P_IDLE;
               end
            end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      if (m_known) begin
         chk("count", int'(bus.count), m_cnt);
         chk("full", int'(bus.full), int'(m_cnt == 8));
         chk("empty", int'(bus.empty), int'(m_cnt == 0));
         chk("almost_full", int'(bus.almost_full), int'(m_cnt >= m_alto));
         chk("almost_empty", int'(bus.almost_empty), int'(m_cnt <= m_bajo));
         chk("error", int'(bus.error), int'(m_err));
         chk("valid_out", int'(bus.valid_out), int'(m_vld));
         chk("state", int'(bus.state), 1 << m_phase);
`ifdef FIFO_CTRL_PEAK_EN
         chk("peak", int'(bus.peak), m_peak);
`endif
      end
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic push_cyc();
      cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
   endtask

   // Reset, then leave INIT immediately so the default thresholds stay in force.
   task automatic restart();
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      idle_cyc();
      idle_cyc();
   endtask

   initial begin
      reset           = 1'b1;
      bus.init        = 1'b0;
      bus.umbral_alto = '0;
      bus.umbral_bajo = '0;
      bus.push        = 1'b0;
      bus.pop         = 1'b0;

      // Reset state, then load alto=5 bajo=2 through INIT
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      chk("rst_state", int'(bus.state), 5'b00001);
      chk("rst_empty", int'(bus.empty), 1);
      cyc(1'b0, 1'b1, 5, 2, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 5, 2, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 5, 2, 1'b0, 1'b0);
      chk("t1_state", int'(bus.state), 5'b00100);

      repeat (5) push_cyc();
      chk("t2_count", int'(bus.count), 5);
      chk("t2_af", int'(bus.almost_full), 1);

      repeat (3) push_cyc();
      chk("t3_full", int'(bus.full), 1);
      push_cyc();
      chk("t3_state", int'(bus.state), 5'b10000);
      cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

      // Simultaneous push+pop while full
      restart();
      repeat (8) push_cyc();
      cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
      chk("t4_count", int'(bus.count), 8);
      chk("t4_valid", int'(bus.valid_out), 1);
      repeat (8) cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      chk("t4_drain_state", int'(bus.state), 5'b00100);

      // Pop on empty in IDLE
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      chk("t5_error", int'(bus.error), 1);

      // Reset in the middle of ACTIVE
      restart();
      repeat (4) push_cyc();
      cyc(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
      chk("t6_count", int'(bus.count), 0);
      chk("t6_state", int'(bus.state), 5'b00001);
      idle_cyc();
      idle_cyc();
      repeat (6) push_cyc();
      chk("t6_af_default", int'(bus.almost_full), 1);

      for (int ep = 0; ep < 12; ep++) begin
         int a, b, k;
         bit pu, po;
         a = $urandom_range(0, 15);
         b = $urandom_range(0, 15);
         k = $urandom_range(0, 3);
         cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
         cyc(1'b0, 1'(k != 0), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat (k) cyc(1'b0, 1'b1, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         idle_cyc();
         for (int c = 0; c < 60; c++) begin
            pu = ($urandom % 100) < 55;
            po = ($urandom % 100) < 45;
            if (m_cnt == 8 && pu && !po && ($urandom % 100) < 90) pu = 1'b0;
            if (m_cnt == 0 && po && ($urandom % 100) < 95) po = 1'b0;
            cyc(1'(($urandom % 100) < 1), 1'b0, 0, 0, pu, po);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control stage directly upstream of the FIFO memory block.
- Arbitrates external push/pop requests and drives the memory's wr_enable/rd_enable so that its free-running 3-bit pointers never overrun or underrun.
- Tracks occupancy and generates full/empty plus programmable almost-full/almost-empty flags.
- Flags overflow/underflow errors and produces a read-valid strobe aligned with the memory's registered output.

Parameters:
- DEPTH, 8: number of memory entries; must equal the memory's entry count.
- PTR_W, 3: log2(DEPTH).
- AF_DEFAULT, 6: almost-full threshold after reset.
- AE_DEFAULT, 1: almost-empty threshold after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- init  in  1  threshold-load request
- umbral_alto  in  PTR_W+1  almost-full threshold; sampled in INIT
- umbral_bajo  in  PTR_W+1  almost-empty threshold; sampled in INIT
- push  in  1  write request
- pop  in  1  read request
- mem_wr_en  out  1  to memory wr_enable
- mem_rd_en  out  1  to memory rd_enable
- valid_out  out  1  memory output holds popped data this cycle
- count  out  PTR_W+1  occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- almost_full  out  1  count>=alto_q
- almost_empty  out  1  count<=bajo_q
- error  out  1  sticky overflow/underflow
- state  out  5  one-hot FSM state

Behaviour:
- Reset values, applied at the first clk edge with reset high:
  - state=RESET (5'b00001), count=0, alto_q=AF_DEFAULT, bajo_q=AE_DEFAULT.
  - valid_out=0, error=0, mem_wr_en=0, mem_rd_en=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
- Flags are combinational decodes of the registered count and thresholds, so they update the cycle after the causing edge.
- FSM encodings (one-hot): RESET 00001, INIT 00010, IDLE 00100, ACTIVE 01000, ERROR 10000.
  - RESET -> INIT on the first edge with reset low.
  - INIT: alto_q/bajo_q load umbral_alto/umbral_bajo every cycle while init=1. Goes to IDLE on the first edge with init=0.
  - IDLE -> INIT if init=1; -> ACTIVE on an accepted push; -> ERROR on a pop request.
  - ACTIVE -> IDLE when the next count is 0 and no error. init is ignored in ACTIVE.
  - ACTIVE -> ERROR on overflow or underflow.
  - ERROR: sticky; only reset exits.
- Acceptance (combinational, only in IDLE/ACTIVE):
  - wr_ok = push & (count<DEPTH | pop).
  - rd_ok = pop & (count>0).
  - mem_wr_en=wr_ok, mem_rd_en=rd_ok. Both enables are 0 in RESET, INIT and ERROR.
- Count update: count += wr_ok - rd_ok.
  - push+pop while full: both accepted, count unchanged. The memory reads the old entry, since its write is non-blocking.
  - push+pop while empty: push accepted, pop rejected as underflow.
- Overflow: push & !wr_ok. Underflow: pop & !rd_ok. Either sets error=1 at the next edge and moves state to ERROR. The rejected operation does not alter count.
- Push/pop in RESET or INIT are ignored; no error.
- valid_out: registered copy of rd_ok, high exactly one cycle after the pop edge. This aligns with FIFO_data_out.
- Thresholds are unsigned. Values >DEPTH make almost_full never assert, which is legal.
- Reset mid-operation: everything returns to reset values at that edge. The memory is reset by the same signal, so its pointers stay consistent.

Optional Feature:
- Macro: FIFO_CTRL_PEAK_EN.
- With the macro defined:
  - Extra output peak (PTR_W+1 bits) holds the maximum count observed since reset; reset value 0.
  - peak updates to the next count whenever that exceeds peak.
- Without the macro: the port and its register are absent.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - the five state encodings, and the state width 5;
  - the default DEPTH/PTR_W values;
  - the AF_DEFAULT/AE_DEFAULT constants.
- One sub-module, fifo_cnt: occupancy counter taking wr_ok/rd_ok and outputting count, full and empty. The FSM, thresholds and error logic stay in fifo_ctrl.

Test Plan:
1. Reset 2 cycles; then init=1 with alto=5, bajo=2 for 1 cycle; then init=0 -> state goes RESET, INIT, IDLE; empty=1, almost_empty=1, full=0, almost_full=0.
2. From case 1, 5 consecutive pushes -> mem_wr_en high 5 cycles; state=ACTIVE; almost_empty falls after the 3rd push; almost_full rises after the 5th; count=5.
3. 3 more pushes -> count=8, full=1. A 9th push without pop -> mem_wr_en=0, error=1, state=ERROR next cycle; later push/pop give no enables.
4. Fresh fill to 8, then push+pop in the same cycle -> mem_wr_en=1, mem_rd_en=1, count stays 8, valid_out=1 the following cycle.
5. In IDLE with count 0, pop=1 -> mem_rd_en=0, valid_out stays 0, error=1, state=ERROR.
6. Reset asserted in ACTIVE with count=4 -> after the edge: count=0, state=RESET, enables 0, error=0, thresholds back to 6/1.
